register_loads: RTL and testbench

- Receiving end of the 6502 internal bus routing: captures the values on the DB, SB, ADL and ADH buses into the CPU's architectural and interface registers.
- Targets: X, Y, S, PCL/PCH (with increment), the address bus registers ABL/ABH, the data output register DOR and the input data latch DL.
- Sits downstream of the bus-drive logic. Its register outputs feed back as that logic's source values and as the external address/data pins.

---
 rtl/register_loads_if.sv | 53 +++++
 rtl/register_loads.sv | 99 +++++++++
 tb/tb_register_loads.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/register_loads_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// register_loads_if : bus values, load controls and register outputs of register_loads
// Rev 1.0
// ---------------------------------------------------------------------------
interface register_loads_if;
  logic [7:0]  i_bus_db;
  logic [7:0]  i_bus_sb;
  logic [7:0]  i_bus_adl;
  logic [7:0]  i_bus_adh;
  logic [7:0]  i_data;
  logic        i_sb_x;
  logic        i_sb_y;
  logic        i_sb_s;
  logic        i_adl_pcl;
  logic        i_adh_pch;
  logic        i_i_pc;
  logic        i_adl_abl;
  logic        i_adh_abh;
  logic        i_db_dor;
  logic [7:0]  o_x;
  logic [7:0]  o_y;
  logic [7:0]  o_s;
  logic [7:0]  o_pcl;
  logic [7:0]  o_pch;
  logic [15:0] o_address;
  logic [7:0]  o_dor;
  logic [7:0]  o_dl;
`ifdef REGISTER_LOADS_TRACE_EN
  logic        o_pc_wrapped;
`endif

  modport master (
    output i_bus_db, i_bus_sb, i_bus_adl, i_bus_adh, i_data,
    output i_sb_x, i_sb_y, i_sb_s, i_adl_pcl, i_adh_pch, i_i_pc,
    output i_adl_abl, i_adh_abh, i_db_dor,
`ifdef REGISTER_LOADS_TRACE_EN
    input  o_pc_wrapped,
`endif
    input  o_x, o_y, o_s, o_pcl, o_pch, o_address, o_dor, o_dl
  );

  modport slave (
    input  i_bus_db, i_bus_sb, i_bus_adl, i_bus_adh, i_data,
    input  i_sb_x, i_sb_y, i_sb_s, i_adl_pcl, i_adh_pch, i_i_pc,
    input  i_adl_abl, i_adh_abh, i_db_dor,
`ifdef REGISTER_LOADS_TRACE_EN
    output o_pc_wrapped,
`endif
    output o_x, o_y, o_s, o_pcl, o_pch, o_address, o_dor, o_dl
  );
endinterface
`default_nettype wire

// File: rtl/register_loads.sv
`default_nettype none
// ---------------------------------------------------------------------------
// register_loads : 6502 register capture from DB/SB/ADL/ADH plus PC incrementer.
// Optional macro REGISTER_LOADS_TRACE_EN adds o_pc_wrapped.  Rev 1.0
// ---------------------------------------------------------------------------
module register_loads #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [7:0]  S_RESET  = 8'hFD
) (
  input  wire logic       i_clk,
  input  wire logic       i_reset,
  register_loads_if.slave bus
);

  logic [7:0] x_q,   x_d;
  logic [7:0] y_q,   y_d;
  logic [7:0] s_q,   s_d;
  logic [7:0] pcl_q, pcl_d;
  logic [7:0] pch_q, pch_d;
  logic [7:0] abl_q, abl_d;
  logic [7:0] abh_q, abh_d;
  logic [7:0] dor_q, dor_d;
  logic [7:0] dl_q,  dl_d;

  logic [7:0] pcl_src;
  logic [7:0] pch_src;
  logic [8:0] pcl_sum;

  always_comb begin
    x_d   = bus.i_sb_x    ? bus.i_bus_sb  : x_q;
    y_d   = bus.i_sb_y    ? bus.i_bus_sb  : y_q;
    s_d   = bus.i_sb_s    ? bus.i_bus_sb  : s_q;
    abl_d = bus.i_adl_abl ? bus.i_bus_adl : abl_q;
    abh_d = bus.i_adh_abh ? bus.i_bus_adh : abh_q;
    dor_d = bus.i_db_dor  ? bus.i_bus_db  : dor_q;
    dl_d  = bus.i_data;
  end

  // Increment acts on the freshly selected source; PCL carry lands in PCH this edge.
  always_comb begin
    pcl_src = bus.i_adl_pcl ? bus.i_bus_adl : pcl_q;
    pch_src = bus.i_adh_pch ? bus.i_bus_adh : pch_q;
    pcl_sum = {1'b0, pcl_src} + 9'd1;
    pcl_d   = pcl_src;
    pch_d   = pch_src;
    if (bus.i_i_pc) begin
      pcl_d = pcl_sum[7:0];
      pch_d = pch_src + {7'd0, pcl_sum[8]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      x_q   <= 8'h00;
      y_q   <= 8'h00;
      s_q   <= S_RESET;
      pcl_q <= PC_RESET[7:0];
      pch_q <= PC_RESET[15:8];
      abl_q <= 8'h00;
      abh_q <= 8'h00;
      dor_q <= 8'h00;
      dl_q  <= 8'h00;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      s_q   <= s_d;
      pcl_q <= pcl_d;
      pch_q <= pch_d;
      abl_q <= abl_d;
      abh_q <= abh_d;
      dor_q <= dor_d;
      dl_q  <= dl_d;
    end
  end

`ifdef REGISTER_LOADS_TRACE_EN
  logic wrapped_q, wrapped_d;

  assign wrapped_d = bus.i_i_pc && ({pch_src, pcl_src} == 16'hFFFF);

  always_ff @(posedge i_clk) begin
    if (i_reset) wrapped_q <= 1'b0;
    else         wrapped_q <= wrapped_d;
  end

  assign bus.o_pc_wrapped = wrapped_q;
`endif

  assign bus.o_x       = x_q;
  assign bus.o_y       = y_q;
  assign bus.o_s       = s_q;
  assign bus.o_pcl     = pcl_q;
  assign bus.o_pch     = pch_q;
  assign bus.o_address = {abh_q, abl_q};
  assign bus.o_dor     = dor_q;
  assign bus.o_dl      = dl_q;

endmodule
`default_nettype wire

// File: tb/tb_register_loads.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_register_loads : directed + random stimulus against a 16-bit PC reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_register_loads;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  register_loads_if rl_if();

  register_loads #(.PC_RESET(16'h0000), .S_RESET(8'hFD)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (rl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [7:0]  m_x, m_y, m_s, m_dor, m_dl;
  logic [15:0] m_pc, m_addr;
  logic        m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ctl = {sb_x, sb_y, sb_s, adl_pcl, adh_pch, i_pc, adl_abl, adh_abh, db_dor}
  task automatic drive(input logic [7:0] db, sb, adl, adh, data, input logic [8:0] ctl);
    rl_if.i_bus_db  = db;
    rl_if.i_bus_sb  = sb;
    rl_if.i_bus_adl = adl;
    rl_if.i_bus_adh = adh;
    rl_if.i_data    = data;
    {rl_if.i_sb_x, rl_if.i_sb_y, rl_if.i_sb_s, rl_if.i_adl_pcl, rl_if.i_adh_pch,
     rl_if.i_i_pc, rl_if.i_adl_abl, rl_if.i_adh_abh, rl_if.i_db_dor} = ctl;
  endtask

  task automatic model_edge();
    logic [15:0] src;
    if (rst) begin
      m_x = 0; m_y = 0; m_s = 8'hFD; m_pc = 16'h0000;
      m_addr = 0; m_dor = 0; m_dl = 0; m_wrap = 0;
    end else begin
      src = {rl_if.i_adh_pch ? rl_if.i_bus_adh : m_pc[15:8],
             rl_if.i_adl_pcl ? rl_if.i_bus_adl : m_pc[7:0]};
      m_wrap = rl_if.i_i_pc && (src == 16'hFFFF);
      m_pc   = src + (rl_if.i_i_pc ? 16'd1 : 16'd0);
      if (rl_if.i_sb_x)    m_x = rl_if.i_bus_sb;
      if (rl_if.i_sb_y)    m_y = rl_if.i_bus_sb;
      if (rl_if.i_sb_s)    m_s = rl_if.i_bus_sb;
      if (rl_if.i_adl_abl) m_addr[7:0]  = rl_if.i_bus_adl;
      if (rl_if.i_adh_abh) m_addr[15:8] = rl_if.i_bus_adh;
      if (rl_if.i_db_dor)  m_dor = rl_if.i_bus_db;
      m_dl = rl_if.i_data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("x",    {24'd0, rl_if.o_x},            {24'd0, m_x});
    check("y",    {24'd0, rl_if.o_y},            {24'd0, m_y});
    check("s",    {24'd0, rl_if.o_s},            {24'd0, m_s});
    check("pc",   {16'd0, rl_if.o_pch, rl_if.o_pcl}, {16'd0, m_pc});
    check("addr", {16'd0, rl_if.o_address},      {16'd0, m_addr});
    check("dor",  {24'd0, rl_if.o_dor},          {24'd0, m_dor});
    check("dl",   {24'd0, rl_if.o_dl},           {24'd0, m_dl});
`ifdef REGISTER_LOADS_TRACE_EN
    check("wrap", {31'd0, rl_if.o_pc_wrapped},   {31'd0, m_wrap});
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_x = 0; m_y = 0; m_s = 0; m_pc = 0; m_addr = 0; m_dor = 0; m_dl = 0; m_wrap = 0;

    // Reset with every control asserted
    rst = 1'b1;
    drive(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 9'h1FF);
    step();
    check("rst_s",  {24'd0, rl_if.o_s}, 32'h0000_00FD);
    check("rst_pc", {16'd0, rl_if.o_pch, rl_if.o_pcl}, 32'h0);
    rst = 1'b0;

    drive(8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 9'b110_000_000);
    step();
    drive(8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 9'b000_000_000);
    step();
    check("x_hold", {24'd0, rl_if.o_x}, 32'h5A);
    check("y_hold", {24'd0, rl_if.o_y}, 32'h5A);

    drive(8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 9'b000_111_000);
    step();
    check("pc_1235", {16'd0, rl_if.o_pch, rl_if.o_pcl}, 32'h1235);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 9'b000_001_000);
    step();
    check("pc_1236", {16'd0, rl_if.o_pch, rl_if.o_pcl}, 32'h1236);

    drive(8'h00, 8'h00, 8'hFF, 8'h12, 8'h00, 9'b000_110_000);
    step();
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 9'b000_001_000);
    step();
    check("pc_1300", {16'd0, rl_if.o_pch, rl_if.o_pcl}, 32'h1300);

    drive(8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 9'b000_110_000);
    step();
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 9'b000_001_000);
    step();
    check("pc_wrap", {16'd0, rl_if.o_pch, rl_if.o_pcl}, 32'h0000);
    step();

    drive(8'h77, 8'h00, 8'hCD, 8'hAB, 8'h99, 9'b000_000_111);
    step();
    check("addr_abcd", {16'd0, rl_if.o_address}, 32'hABCD);
    drive(8'h11, 8'h00, 8'h22, 8'h33, 8'h44, 9'b000_000_000);
    step();

    // Increment from 0x0010, reset mid-stream
    drive(8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 9'b000_110_000);
    step();
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 9'b000_001_000);
    step(); step(); step();
    check("pc_0013", {16'd0, rl_if.o_pch, rl_if.o_pcl}, 32'h0013);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("pc_0001", {16'd0, rl_if.o_pch, rl_if.o_pcl}, 32'h0001);

    // Random traffic; PC operands biased toward FF to exercise carry and wrap
    for (int i = 0; i < 400; i++) begin
      logic [7:0] adl, adh;
      adl = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      adh = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      rst = ($urandom_range(0, 40) == 0);
      drive(8'($urandom), 8'($urandom), adl, adh, 8'($urandom), 9'($urandom));
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
